// File: rtl/seq_chunk_alu_if.sv
// Request/result handshake bundle for seq_chunk_alu.
// master drives operands and result acceptance; slave is the ALU itself.
interface seq_chunk_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bit1;
  logic [WIDTH-1:0] bit2;
  logic [2:0]       Alu_Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             set;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, bit1, bit2, Alu_Op, out_ready,
    input  in_ready, out_valid, res, set, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, bit1, bit2, Alu_Op, out_ready,
    output in_ready, out_valid, res, set, carry_out, overflow, zero
  );
endinterface

// File: rtl/seq_chunk_alu.sv
// Multi-cycle ALU: one CHUNK-bit carry-lookahead slice walks the operands
// LSB chunk first, so a result appears NCHUNK cycles after acceptance.
module seq_chunk_alu #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_chunk_alu_if.slave    bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR  = 3'b001, OP_XOR = 3'b010, OP_NOR = 3'b011,
    OP_ADD = 3'b100, OP_SUB = 3'b101, OP_SLT = 3'b110, OP_RSV = 3'b111
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             set_q, co_q, ov_q, zero_q;

  logic             last_chunk;
  logic             is_arith, is_sub;
  logic [BW-1:0]    base;
  logic [CHUNK-1:0] a_c, b_c, b_eff, g, p, sum, chunk_res;
  logic [CHUNK:0]   c;
  logic [WIDTH-1:0] res_full;
  logic             set_n, co_n, ov_n, zero_n;

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
  assign is_sub     = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign is_arith   = (op_q == OP_ADD) || is_sub;
  assign base       = BW'(BW'(idx_q) * BW'(CHUNK));

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    a_c   = a_q[base +: CHUNK];
    b_c   = b_q[base +: CHUNK];
    b_eff = is_sub ? ~b_c : b_c;
    g     = a_c & b_eff;
    p     = a_c ^ b_eff;
    c     = '0;
    c[0]  = carry_q;
    // Generate/propagate recurrence; synthesis flattens it into lookahead terms.
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p ^ c[CHUNK-1:0];

    unique case (op_q)
      OP_AND:                 chunk_res = a_c & b_c;
      OP_OR:                  chunk_res = a_c | b_c;
      OP_XOR:                 chunk_res = a_c ^ b_c;
      OP_NOR:                 chunk_res = ~(a_c | b_c);
      OP_ADD, OP_SUB, OP_SLT: chunk_res = sum;
      default:                chunk_res = '0;
    endcase

    ov_n  = is_arith & (c[CHUNK] ^ c[CHUNK-1]);
    co_n  = is_arith & c[CHUNK];
    set_n = is_sub & (sum[CHUNK-1] ^ ov_n);

    res_full = res_q;
    res_full[base +: CHUNK] = chunk_res;
    if (last_chunk && op_q == OP_SLT) begin
      res_full = {{(WIDTH-1){1'b0}}, set_n};
    end
    zero_n = ~|res_full;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      set_q   <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.bit1;
            b_q     <= bus.bit2;
            op_q    <= op_e'(bus.Alu_Op);
            idx_q   <= '0;
            // Subtraction is A + ~B + 1: the +1 enters as chunk 0 carry-in.
            carry_q <= (bus.Alu_Op == OP_SUB) || (bus.Alu_Op == OP_SLT);
            res_q   <= '0;
            set_q   <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
          end
        end
        CALC: begin
          res_q   <= res_full;
          carry_q <= c[CHUNK];
          if (last_chunk) begin
            idx_q  <= '0;
            set_q  <= set_n;
            co_q   <= co_n;
            ov_q   <= ov_n;
            zero_q <= zero_n;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.res       = res_q;
  assign bus.set       = set_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_chunk_alu.sv
// Scoreboard bench for seq_chunk_alu (WIDTH=32, CHUNK=4): driver queues
// hand-computed results, a negedge monitor pops them on each result handshake.
module tb_seq_chunk_alu;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             set;
    logic             co;
    logic             ov;
    logic             zero;
  } exp_t;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    exp_t             e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t vq[$];

  always #5 clk = ~clk;

  seq_chunk_alu_if #(.WIDTH(WIDTH)) dut_if ();

  seq_chunk_alu #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic s, input logic co,
                              input logic ov, input logic z);
    exp_t e;
    e = '{res: r, set: s, co: co, ov: ov, zero: z};
    return e;
  endfunction

  task automatic add_vec(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input exp_t e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.e = e;
    vq.push_back(v);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && dut_if.out_valid && dut_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({dut_if.res, dut_if.set, dut_if.carry_out,
                             dut_if.overflow, dut_if.zero}), 64'(e));
      end
    end
  end

  // Presents one request and returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit push, input exp_t e);
    int n;
    @(negedge clk);
    n = 0;
    while (!dut_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'(n), 64'd0);
    dut_if.in_valid = 1'b1;
    dut_if.bit1     = a;
    dut_if.bit2     = b;
    dut_if.Alu_Op   = op;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    dut_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dut_if.out_valid && n < 20);
    check(name, 64'(n), 64'd8);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b1;
    dut_if.bit1      = '0;
    dut_if.bit2      = '0;
    dut_if.Alu_Op    = 3'b000;

    add_vec(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 0, 1, 0, 1));
    add_vec(3'b101, 32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1, 1, 1, 0));
    add_vec(3'b110, 32'hFFFF_FFFB, 32'h0000_0003, mk(32'h0000_0001, 1, 1, 0, 0));
    add_vec(3'b110, 32'h7FFF_FFFF, 32'h8000_0000, mk(32'h0000_0000, 0, 0, 1, 1));
    add_vec(3'b010, 32'hA5A5_A5A5, 32'hFFFF_0000, mk(32'h5A5A_A5A5, 0, 0, 0, 0));
    add_vec(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0000_0000, 0, 0, 0, 1));
    add_vec(3'b000, 32'hF0F0_F0F0, 32'h1234_5678, mk(32'h1030_5070, 0, 0, 0, 0));
    add_vec(3'b001, 32'h1234_0000, 32'h0000_5678, mk(32'h1234_5678, 0, 0, 0, 0));
    add_vec(3'b011, 32'h0000_0000, 32'h0000_0000, mk(32'hFFFF_FFFF, 0, 0, 0, 0));
    add_vec(3'b011, 32'hFFFF_FFFF, 32'h0000_0000, mk(32'h0000_0000, 0, 0, 0, 1));
    add_vec(3'b100, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 0, 1, 0));
    add_vec(3'b101, 32'h0000_0005, 32'h0000_0005, mk(32'h0000_0000, 0, 1, 0, 1));
    add_vec(3'b101, 32'h0000_0003, 32'h0000_0005, mk(32'hFFFF_FFFE, 1, 0, 0, 0));

    // Reset state while rst_n is held low.
    #12;
    check("reset_state", 64'({dut_if.res, dut_if.set, dut_if.carry_out, dut_if.overflow,
                              dut_if.zero, dut_if.out_valid, dut_if.in_ready}),
          64'({32'h0, 4'b0000, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      issue(vq[i].op, vq[i].a, vq[i].b, 1'b1, vq[i].e);
      wait_done($sformatf("latency_%0d", i));
    end

    // Backpressure: result must hold while inputs churn and out_ready is low.
    @(posedge clk);
    #1;
    dut_if.out_ready = 1'b0;
    issue(3'b100, 32'h1234_5678, 32'h1111_1111, 1'b1, mk(32'h2345_6789, 0, 0, 0, 0));
    wait_done("latency_bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dut_if.in_valid = ~dut_if.in_valid;
      dut_if.bit1     = $urandom;
      dut_if.bit2     = $urandom;
      dut_if.Alu_Op   = 3'($urandom_range(0, 7));
      check($sformatf("bp_hold_%0d", k),
            64'({dut_if.res, dut_if.set, dut_if.carry_out, dut_if.overflow, dut_if.zero,
                 dut_if.in_ready, dut_if.out_valid}),
            64'({32'h2345_6789, 4'b0000, 1'b0, 1'b1}));
    end
    @(posedge clk);
    #1;
    dut_if.in_valid  = 1'b0;
    dut_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 64'({dut_if.in_ready, dut_if.out_valid}), 64'({1'b1, 1'b0}));

    // Reset during the 4th CALC cycle aborts the ADD with nothing retained.
    issue(3'b100, 32'h0000_0005, 32'h0000_0006, 1'b0, mk('0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", 64'({dut_if.res, dut_if.set, dut_if.carry_out, dut_if.overflow,
                              dut_if.zero, dut_if.out_valid, dut_if.in_ready}),
          64'({32'h0, 4'b0000, 1'b0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b100, 32'h0000_0002, 32'h0000_0003, 1'b1, mk(32'h0000_0005, 0, 0, 0, 0));
    wait_done("latency_post_reset");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
